pipeline_flow_ctrl: RTL and testbench

PIPELINE_FLOW_CTRL -- requirements
Module: pipeline_flow_ctrl

---
 rtl/pipeline_flow_ctrl.sv | 133 +++++++++++++
 tb/tb_pipeline_flow_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_flow_ctrl.sv
// Pipeline hazard/flow controller: memory stalls, load-use bubbles, jump redirect and refill.
// Latency: stall/bubble/flush are combinational; redirect request and counters are registered (1 cycle).
// Backpressure: mem_busy freezes everything; redirect is held until fetch asserts redirect_ready.
module pipeline_flow_ctrl #(
  parameter int REFILL_CYCLES = 3,
  parameter int REG_IDX_W     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rr_valid,
  input  logic                 rr_src1_used,
  input  logic                 rr_src2_used,
  input  logic [REG_IDX_W-1:0] rr_src1_idx,
  input  logic [REG_IDX_W-1:0] rr_src2_idx,
  input  logic                 ex_valid,
  input  logic                 ex_is_load,
  input  logic                 ex_dst_wr,
  input  logic [REG_IDX_W-1:0] ex_dst_idx,
  input  logic                 ex_is_jmp,
  input  logic [31:0]          ex_jmp_target,
  input  logic                 mem_busy,
  input  logic                 redirect_ready,
  output logic                 stall_all,
  output logic                 stall_front,
  output logic                 bubble_ex,
  output logic                 flush_front,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_pc,
  output logic [1:0]           state,
  output logic [15:0]          stall_count,
  output logic [15:0]          flush_count,
  output logic                 err_refill
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEMWAIT  = 2'd1,
    REDIRECT = 2'd2,
    REFILL   = 2'd3
  } state_t;

  localparam logic [3:0] REFILL_LAST = 4'(REFILL_CYCLES - 1);

  state_t      cur_state, nxt_state;
  logic [3:0]  refill_cnt, refill_cnt_nxt;
  logic        redirect_valid_nxt;
  logic [31:0] redirect_pc_nxt;
  logic        flush_inc;
  logic        load_use;

  assign state = cur_state;

  assign load_use = rr_valid & ex_valid & ex_is_load & ex_dst_wr &
                    ((rr_src1_used & (rr_src1_idx == ex_dst_idx)) |
                     (rr_src2_used & (rr_src2_idx == ex_dst_idx)));

  always_comb begin
    nxt_state          = cur_state;
    refill_cnt_nxt     = refill_cnt;
    redirect_valid_nxt = redirect_valid;
    redirect_pc_nxt    = redirect_pc;
    flush_inc          = 1'b0;
    stall_all          = 1'b0;
    stall_front        = 1'b0;
    bubble_ex          = 1'b0;
    flush_front        = 1'b0;
    unique case (cur_state)
      // MEMWAIT without mem_busy replays RUN so a jump frozen in EX still redirects
      RUN, MEMWAIT: begin
        if (mem_busy) begin
          stall_all = 1'b1;
          nxt_state = MEMWAIT;
        end else if (ex_valid && ex_is_jmp) begin
          flush_front        = 1'b1;
          redirect_pc_nxt    = ex_jmp_target;
          redirect_valid_nxt = 1'b1;
          flush_inc          = 1'b1;
          nxt_state          = REDIRECT;
        end else begin
          nxt_state = RUN;
          if (load_use) begin
            stall_front = 1'b1;
            bubble_ex   = 1'b1;
          end
        end
      end
      REDIRECT: begin
        flush_front = redirect_valid;
        if (mem_busy) begin
          stall_all = 1'b1;
        end else if (redirect_ready) begin
          redirect_valid_nxt = 1'b0;
          refill_cnt_nxt     = REFILL_LAST;
          nxt_state          = REFILL;
        end
      end
      REFILL: begin
        if (mem_busy) begin
          stall_all = 1'b1;
        end else if (refill_cnt == 4'd0) begin
          nxt_state = RUN;
        end else begin
          refill_cnt_nxt = refill_cnt - 4'd1;
        end
      end
      default: nxt_state = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_state      <= RUN;
      refill_cnt     <= 4'd0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
      stall_count    <= 16'd0;
      flush_count    <= 16'd0;
      err_refill     <= 1'b0;
    end else begin
      cur_state      <= nxt_state;
      refill_cnt     <= refill_cnt_nxt;
      redirect_valid <= redirect_valid_nxt;
      redirect_pc    <= redirect_pc_nxt;
      if ((stall_all || stall_front) && stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
      if (flush_inc && flush_count != 16'hFFFF)
        flush_count <= flush_count + 16'd1;
      if (cur_state == REFILL && ex_valid)
        err_refill <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_flow_ctrl.sv
// Directed bench for pipeline_flow_ctrl; redirect PCs are scoreboarded through a queue.
module tb_pipeline_flow_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rr_valid, rr_src1_used, rr_src2_used;
  logic [2:0]  rr_src1_idx, rr_src2_idx;
  logic        ex_valid, ex_is_load, ex_dst_wr;
  logic [2:0]  ex_dst_idx;
  logic        ex_is_jmp;
  logic [31:0] ex_jmp_target;
  logic        mem_busy, redirect_ready;
  logic        stall_all, stall_front, bubble_ex, flush_front;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [1:0]  state;
  logic [15:0] stall_count, flush_count;
  logic        err_refill;

  int vectors = 0;
  int miscompares = 0;
  int exp_stall = 0;
  int exp_flush = 0;
  logic [31:0] exp_pc[$];
  logic [31:0] hold_pc = 32'd0;
  logic        prev_rv = 1'b0;

  pipeline_flow_ctrl #(.REFILL_CYCLES(3), .REG_IDX_W(3)) dut (
    .clk(clk), .rst(rst),
    .rr_valid(rr_valid), .rr_src1_used(rr_src1_used), .rr_src2_used(rr_src2_used),
    .rr_src1_idx(rr_src1_idx), .rr_src2_idx(rr_src2_idx),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_dst_wr(ex_dst_wr),
    .ex_dst_idx(ex_dst_idx), .ex_is_jmp(ex_is_jmp), .ex_jmp_target(ex_jmp_target),
    .mem_busy(mem_busy), .redirect_ready(redirect_ready),
    .stall_all(stall_all), .stall_front(stall_front), .bubble_ex(bubble_ex),
    .flush_front(flush_front), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .state(state), .stall_count(stall_count), .flush_count(flush_count),
    .err_refill(err_refill)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rr_valid = 0; rr_src1_used = 0; rr_src2_used = 0;
    rr_src1_idx = 0; rr_src2_idx = 0;
    ex_valid = 0; ex_is_load = 0; ex_dst_wr = 0; ex_dst_idx = 0;
    ex_is_jmp = 0; ex_jmp_target = 0;
    mem_busy = 0; redirect_ready = 0;
  endtask

  task automatic drive_lu(input logic s1u, input logic [2:0] s1, input logic s2u,
                          input logic [2:0] s2, input logic dw, input logic [2:0] d);
    rr_valid = 1; rr_src1_used = s1u; rr_src1_idx = s1;
    rr_src2_used = s2u; rr_src2_idx = s2;
    ex_valid = 1; ex_is_load = 1; ex_dst_wr = dw; ex_dst_idx = d;
  endtask

  task automatic lu_case(input logic s1u, input logic [2:0] s1, input logic s2u,
                         input logic [2:0] s2, input logic dw, input logic [2:0] d,
                         input logic exp);
    drive_lu(s1u, s1, s2u, s2, dw, d);
    #1;
    chk("lu_stall_front", stall_front, exp);
    chk("lu_bubble_ex", bubble_ex, exp);
    chk("lu_stall_all", stall_all, 0);
    if (exp) exp_stall++;
    @(negedge clk);
    // the bubble empties EX; RR stays put
    ex_valid = 0;
    #1;
    chk("lu_release", stall_front, 0);
    chk("lu_state", state, 0);
    chk("stall_count", stall_count, exp_stall);
    @(negedge clk);
    idle();
  endtask

  // Scoreboard: each new redirect must match the oldest queued jump target and stay stable.
  always @(negedge clk) begin
    if (!rst) begin
      prev_rv = 1'b0;
    end else begin
      if (redirect_valid && !prev_rv) begin
        chk("redirect_expected", exp_pc.size() != 0, 1);
        if (exp_pc.size() != 0) begin
          hold_pc = exp_pc.pop_front();
          chk("redirect_pc", redirect_pc, hold_pc);
        end
      end else if (redirect_valid) begin
        chk("redirect_pc_hold", redirect_pc, hold_pc);
      end
      prev_rv = redirect_valid;
    end
  end

  initial begin
    idle();
    @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_redirect_valid", redirect_valid, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_stall_count", stall_count, 0);
    chk("rst_flush_count", flush_count, 0);
    chk("rst_err_refill", err_refill, 0);
    rst = 1;
    #1;
    chk("idle_comb", {stall_all, stall_front, bubble_ex, flush_front}, 0);
    @(negedge clk);

    // Basic jump: flush same cycle, redirect next, three REFILL cycles
    ex_valid = 1; ex_is_jmp = 1; ex_jmp_target = 32'h0000_0040; redirect_ready = 1;
    exp_pc.push_back(32'h0000_0040);
    #1;
    chk("jmp_flush_front", flush_front, 1);
    chk("jmp_stall_all", stall_all, 0);
    chk("jmp_bubble_ex", bubble_ex, 0);
    exp_flush++;
    @(negedge clk);
    chk("jmp_state_redirect", state, 2);
    chk("jmp_redirect_valid", redirect_valid, 1);
    idle(); redirect_ready = 1;
    #1;
    chk("redirect_flush_front", flush_front, 1);
    @(negedge clk);
    idle();
    chk("refill_entry", state, 3);
    chk("refill_rv_low", redirect_valid, 0);
    #1;
    chk("refill_no_flush", flush_front, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("refill_hold", state, 3);
    end
    @(negedge clk);
    chk("refill_done", state, 0);
    chk("flush_count_1", flush_count, exp_flush);
    chk("stall_count_0", stall_count, exp_stall);

    // Load-use detection across several operand patterns
    lu_case(1, 3'd0, 0, 3'd0, 1, 3'd0, 1);
    lu_case(0, 3'd5, 1, 3'd5, 1, 3'd5, 1);
    lu_case(0, 3'd5, 0, 3'd5, 1, 3'd5, 0);
    lu_case(1, 3'd2, 0, 3'd0, 0, 3'd2, 0);
    lu_case(1, 3'd3, 1, 3'd4, 1, 3'd6, 0);

    // Jump frozen behind mem_busy for 4 cycles
    ex_valid = 1; ex_is_jmp = 1; ex_jmp_target = 32'h1234_5678; mem_busy = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("mw_stall_all", stall_all, 1);
      chk("mw_no_flush", flush_front, 0);
      exp_stall++;
      @(negedge clk);
      chk("mw_state", state, 1);
      chk("mw_no_redirect", redirect_valid, 0);
    end
    mem_busy = 0;
    exp_pc.push_back(32'h1234_5678);
    #1;
    chk("mw_release_flush", flush_front, 1);
    chk("mw_release_stall", stall_all, 0);
    exp_flush++;
    @(negedge clk);
    chk("mw_redirect_state", state, 2);
    chk("flush_count_2", flush_count, exp_flush);
    chk("stall_count_mw", stall_count, exp_stall);

    // Redirect held while fetch is not ready, then mem_busy overrides ready
    idle();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("hold_flush_front", flush_front, 1);
      chk("hold_stall_all", stall_all, 0);
      @(negedge clk);
      chk("hold_state", state, 2);
      chk("hold_rv", redirect_valid, 1);
    end
    mem_busy = 1; redirect_ready = 1;
    #1;
    chk("redir_busy_stall", stall_all, 1);
    exp_stall++;
    @(negedge clk);
    chk("redir_busy_state", state, 2);
    chk("redir_busy_rv", redirect_valid, 1);
    mem_busy = 0;
    @(negedge clk);
    chk("redir_accept_state", state, 3);
    chk("redir_accept_rv", redirect_valid, 0);

    // REFILL: mem_busy freezes it; jump/load-use ignored; ex_valid flags an error
    idle(); mem_busy = 1;
    #1;
    chk("refill_busy_stall", stall_all, 1);
    chk("refill_busy_flush", flush_front, 0);
    exp_stall++;
    @(negedge clk);
    chk("refill_busy_state", state, 3);
    idle();
    drive_lu(1, 3'd1, 0, 3'd0, 1, 3'd1);
    ex_is_jmp = 1; ex_jmp_target = 32'hDEAD_0000;
    #1;
    chk("refill_jmp_no_flush", flush_front, 0);
    chk("refill_lu_no_bubble", bubble_ex, 0);
    chk("refill_lu_no_stall", stall_front, 0);
    @(negedge clk);
    idle();
    chk("err_refill_set", err_refill, 1);
    chk("refill_ex_state", state, 3);
    @(negedge clk);
    chk("refill_last", state, 3);
    @(negedge clk);
    chk("refill_exit", state, 0);
    chk("err_refill_sticky", err_refill, 1);
    chk("stall_count_mid", stall_count, exp_stall);
    chk("flush_count_mid", flush_count, exp_flush);

    // Jump and load-use together: flush wins, no bubble
    drive_lu(1, 3'd4, 0, 3'd0, 1, 3'd4);
    ex_is_jmp = 1; ex_jmp_target = 32'h0000_0100;
    exp_pc.push_back(32'h0000_0100);
    #1;
    chk("jmp_lu_flush", flush_front, 1);
    chk("jmp_lu_no_bubble", bubble_ex, 0);
    chk("jmp_lu_no_stall", stall_front, 0);
    exp_flush++;
    @(negedge clk);
    idle(); redirect_ready = 1;
    chk("jmp_lu_state", state, 2);
    chk("flush_count_3", flush_count, exp_flush);
    @(negedge clk);
    idle();
    chk("pre_reset_refill", state, 3);

    // Asynchronous reset in the middle of REFILL, away from any clock edge
    #2 rst = 0;
    #1;
    chk("arst_state", state, 0);
    chk("arst_rv", redirect_valid, 0);
    chk("arst_rpc", redirect_pc, 0);
    chk("arst_stall_count", stall_count, 0);
    chk("arst_flush_count", flush_count, 0);
    chk("arst_err_refill", err_refill, 0);
    @(negedge clk);
    rst = 1;
    #1;
    chk("post_rst_comb", {stall_all, stall_front, bubble_ex, flush_front}, 0);
    @(negedge clk);
    chk("post_rst_state", state, 0);
    chk("post_rst_rv", redirect_valid, 0);
    exp_stall = 0;
    exp_flush = 0;

    // Saturation of stall_count
    drive_lu(1, 3'd7, 0, 3'd0, 1, 3'd7);
    while (exp_stall < 65534) begin
      @(negedge clk);
      exp_stall++;
    end
    chk("stall_count_fffe", stall_count, 16'hFFFE);
    while (exp_stall < 70000) begin
      @(negedge clk);
      exp_stall++;
    end
    chk("stall_count_sat", stall_count, 16'hFFFF);
    chk("sat_state", state, 0);
    idle();
    @(negedge clk);
    chk("scoreboard_empty", exp_pc.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
